// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: size codes,
// FSM state encoding, lane geometry and the alignment rule.
package mem_access_ctrl_pkg;

  localparam int unsigned MAC_NBITS = 32;
  localparam int unsigned MAC_LANES = MAC_NBITS / 8;

  typedef enum logic [1:0] {
    SZ_INV  = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ERR
  } state_e;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    case (size_e'(size))
      SZ_BYTE: is_legal = 1'b1;
      SZ_HALF: is_legal = ~off[0];
      SZ_WORD: is_legal = (off == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and memory-side signals of mem_access_ctrl; slave is the
// controller's view, master is the view of whatever surrounds it.
interface mem_access_ctrl_if #(
  parameter int NBITS  = 32,
  parameter int SIZE   = 2,
  parameter int ADDR_W = 32
);
  logic              i_valid;
  logic              i_we;
  logic [SIZE-1:0]   i_size;
  logic              i_sign;
  logic [ADDR_W-1:0] i_addr;
  logic [NBITS-1:0]  i_wdata;
  logic              o_stall;
  logic              o_rvalid;
  logic [NBITS-1:0]  o_rdata;
  logic              o_misalign;
  logic              o_fault;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [NBITS/8-1:0] o_mem_be;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [NBITS-1:0]  o_mem_wdata;
  logic              i_mem_ack;
  logic [NBITS-1:0]  i_mem_rdata;

  modport slave (
    input  i_valid, i_we, i_size, i_sign, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    output o_stall, o_rvalid, o_rdata, o_misalign, o_fault,
           o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_valid, i_we, i_size, i_sign, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
    input  o_stall, o_rvalid, o_rdata, o_misalign, o_fault,
           o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational lane steering: byte enables and replicated store data from
// size/offset, plus extraction and sign/zero extension of load data.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]           size_i,
  input  logic [1:0]           off_i,
  input  logic                 sign_i,
  input  logic [MAC_NBITS-1:0] wdata_i,
  input  logic [MAC_NBITS-1:0] rdata_i,
  output logic [MAC_LANES-1:0] be_o,
  output logic [MAC_NBITS-1:0] wdata_o,
  output logic [MAC_NBITS-1:0] ldata_o
);

  logic [MAC_NBITS-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    be_o    = '0;
    wdata_o = '0;
    ldata_o = '0;
    case (size_e'(size_i))
      SZ_BYTE: begin
        be_o    = MAC_LANES'(1) << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = MAC_LANES'(3) << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        ldata_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be_o    = '1;
        wdata_o = wdata_i;
        ldata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: accepts one access, rejects misaligned ones,
// runs the memory handshake and returns extended load data.
// Optional ack-wait timeout enabled by defining MEMCTRL_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int SIZE    = 2,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  mem_access_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic              accept;
  logic              we_q, sign_q;
  logic [SIZE-1:0]   size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NBITS-1:0]  wdata_q;
  logic [NBITS-1:0]  rdata_q, rdata_d;
  logic [NBITS/8-1:0] be;
  logic [NBITS-1:0]  wdata_rep, ld_data;
  logic              in_req;

  assign in_req = (state_q == ST_REQ);

  mem_lane_align u_align (
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .sign_i  (sign_q),
    .wdata_i (wdata_q),
    .rdata_i (bus.i_mem_rdata),
    .be_o    (be),
    .wdata_o (wdata_rep),
    .ldata_o (ld_data)
  );

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_q;
  logic             fault_q;
  logic             tmo_hit;

  assign tmo_hit = in_req && !bus.i_mem_ack && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= tmo_hit;
      if (accept) tmo_q <= '0;
      else if (in_req && !bus.i_mem_ack) tmo_q <= tmo_q + 1'b1;
    end
  end

  assign bus.o_fault = fault_q;
`else
  logic tmo_unused;
  assign tmo_unused  = (TIMEOUT > 0);
  assign bus.o_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          accept  = 1'b1;
          state_d = is_legal(bus.i_size[1:0], bus.i_addr[1:0]) ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        if (bus.i_mem_ack) state_d = ST_RESP;
`ifdef MEMCTRL_TIMEOUT_EN
        else if (tmo_hit) state_d = ST_IDLE;
`endif
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Load result is captured at ack and held until the next completion.
  always_comb begin
    rdata_d = rdata_q;
    if (in_req && bus.i_mem_ack) rdata_d = we_q ? '0 : ld_data;
`ifdef MEMCTRL_TIMEOUT_EN
    else if (tmo_hit) rdata_d = '0;
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= bus.i_we;
        sign_q  <= bus.i_sign;
        size_q  <= bus.i_size;
        addr_q  <= bus.i_addr;
        wdata_q <= bus.i_wdata;
      end
    end
  end

  assign bus.o_stall     = !i_reset && ((state_q == ST_IDLE && bus.i_valid) || in_req);
  assign bus.o_rvalid    = (state_q == ST_RESP);
  assign bus.o_misalign  = (state_q == ST_ERR);
  assign bus.o_rdata     = rdata_q;
  assign bus.o_mem_en    = in_req;
  assign bus.o_mem_we    = in_req & we_q;
  assign bus.o_mem_be    = in_req ? be : '0;
  assign bus.o_mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.o_mem_wdata = in_req ? wdata_rep : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed and random accesses against
// an arithmetic reference model, with a memory responder and output monitor.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.NBITS(32), .SIZE(2), .ADDR_W(32)) bus ();

  mem_access_ctrl #(.NBITS(32), .SIZE(2), .ADDR_W(32), .TIMEOUT(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    bit          misalign;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int unsigned delay;
  } memx_t;

  resp_t       exp_q[$];
  memx_t       mem_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, straight from the access rules.
  function automatic bit m_legal(input int unsigned size, input int unsigned a);
    case (size)
      1: return 1'b1;
      2: return (a % 2) == 0;
      3: return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned m_nbytes(input int unsigned size);
    return (size == 1) ? 1 : (size == 2) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input int unsigned size, input int unsigned a);
    if (size == 3) return 4'd15;
    return 4'((2 ** m_nbytes(size) - 1) * (2 ** (a % 4)));
  endfunction

  function automatic logic [31:0] m_wdata(input int unsigned size, input longint wd);
    case (size)
      1: return 32'((wd % 256) * 32'h0101_0101);
      2: return 32'((wd % 65536) * 32'h0001_0001);
      default: return 32'(wd);
    endcase
  endfunction

  function automatic logic [31:0] m_load(input int unsigned size, input bit sign,
                                         input int unsigned a, input logic [31:0] word);
    longint      v;
    longint      span;
    int unsigned n;
    n = m_nbytes(size);
    v = longint'({32'd0, word}) / (longint'(1) << (8 * (a % 4)));
    if (n < 4) begin
      span = longint'(1) << (8 * n);
      v    = v % span;
      if (sign && v >= span / 2) v = v - span;
    end
    return 32'(v);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"},   {31'b0, bus.o_mem_en},   32'd0);
    check({tag, "_mem_we"},   {31'b0, bus.o_mem_we},   32'd0);
    check({tag, "_mem_be"},   {28'b0, bus.o_mem_be},   32'd0);
    check({tag, "_mem_addr"}, bus.o_mem_addr,          32'd0);
    check({tag, "_mem_wdata"}, bus.o_mem_wdata,        32'd0);
    check({tag, "_stall"},    {31'b0, bus.o_stall},    32'd0);
    check({tag, "_rvalid"},   {31'b0, bus.o_rvalid},   32'd0);
    check({tag, "_misalign"}, {31'b0, bus.o_misalign}, 32'd0);
    check({tag, "_fault"},    {31'b0, bus.o_fault},    32'd0);
    check({tag, "_rdata"},    bus.o_rdata,             32'd0);
  endtask

  // Output monitor: pops one expectation per completion or rejection.
  always @(negedge clk) begin
    if (rst) begin
      last_rdata = '0;
    end else begin
      check("fault_idle", {31'b0, bus.o_fault}, 32'd0);
      if (bus.o_rvalid || bus.o_misalign) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {30'b0, bus.o_rvalid, bus.o_misalign}, 32'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("resp_kind", {30'b0, bus.o_rvalid, bus.o_misalign}, e.misalign ? 32'd1 : 32'd2);
          check("stall_at_resp", {31'b0, bus.o_stall}, 32'd0);
          check("mem_en_at_resp", {31'b0, bus.o_mem_en}, 32'd0);
          if (!e.misalign) begin
            check("rdata", bus.o_rdata, e.rdata);
            last_rdata = e.rdata;
          end else begin
            check("rdata_hold_err", bus.o_rdata, last_rdata);
          end
        end
      end else begin
        check("rdata_hold", bus.o_rdata, last_rdata);
      end
    end
  end

  // Memory responder: checks the request every REQ cycle, acks after the
  // chosen delay, and throws stray acks when no request is pending.
  initial begin
    memx_t m;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_mem_en) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_en", {31'b0, bus.o_mem_en}, 32'd0);
        end else begin
          m = mem_q.pop_front();
          for (int unsigned c = 0; c <= m.delay; c++) begin
            if (rst) break;
            check("mem_en",   {31'b0, bus.o_mem_en}, 32'd1);
            check("stall_req", {31'b0, bus.o_stall}, 32'd1);
            check("mem_we",   {31'b0, bus.o_mem_we}, {31'b0, m.we});
            check("mem_be",   {28'b0, bus.o_mem_be}, {28'b0, m.be});
            check("mem_addr", bus.o_mem_addr, m.addr);
            if (m.we) check("mem_wdata", bus.o_mem_wdata, m.wdata);
            bus.i_mem_ack   = (c == m.delay);
            bus.i_mem_rdata = (c == m.delay) ? m.word : $urandom;
            @(negedge clk);
          end
        end
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = $urandom;
      end else begin
        bus.i_mem_ack   = ($urandom_range(0, 3) == 0);
        bus.i_mem_rdata = $urandom;
      end
    end
  end

  task automatic scramble_inputs();
    bus.i_valid = 1'($urandom);
    bus.i_we    = 1'($urandom);
    bus.i_size  = 2'($urandom);
    bus.i_sign  = 1'($urandom);
    bus.i_addr  = $urandom;
    bus.i_wdata = $urandom;
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] word, input int unsigned delay);
    resp_t       r;
    memx_t       m;
    bit          legal;
    int unsigned c;
    legal      = m_legal(size, addr);
    r.misalign = !legal;
    r.rdata    = we ? 32'd0 : m_load(size, sign, addr, word);
    if (legal) begin
      m.we    = we;
      m.be    = m_be(size, addr);
      m.addr  = addr - (addr % 4);
      m.wdata = m_wdata(size, longint'({32'd0, wd}));
      m.word  = word;
      m.delay = delay;
      mem_q.push_back(m);
    end
    exp_q.push_back(r);
    bus.i_valid = 1'b1;
    bus.i_we    = we;
    bus.i_size  = size;
    bus.i_sign  = sign;
    bus.i_addr  = addr;
    bus.i_wdata = wd;
    #1;
    check("stall_accept", {31'b0, bus.o_stall}, 32'd1);
    @(posedge clk);
    #1;
    scramble_inputs();
    c = 0;
    while (exp_q.size() != 0 && c < delay + 20) begin
      @(posedge clk);
      c++;
    end
    #1;
    bus.i_valid = 1'b0;
    if (exp_q.size() != 0) begin
      check("resp_wait_bound", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      mem_q.delete();
    end else begin
      check("latency", c, legal ? delay + 2 : 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_size  = '0;
    bus.i_sign  = 1'b0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(1'b0, 2'b01, 1'b1, 32'h0000_1003, 32'h0, 32'h8012_3456, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 2);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 10);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_5000, 32'h0, 32'h0, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_6002, 32'h0, 32'h0, 0);
    issue(1'b0, 2'b10, 1'b1, 32'h0000_7002, 32'h0, 32'h8001_7FFF, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_8001, 32'h0, 32'h1122_F344, 0);

    // Reset while the memory request is outstanding.
    begin
      memx_t m;
      m.we = 1'b0; m.be = 4'hF; m.addr = 32'h0000_9000;
      m.wdata = '0; m.word = 32'hDEAD_BEEF; m.delay = 40;
      mem_q.push_back(m);
      bus.i_valid = 1'b1;
      bus.i_we    = 1'b0;
      bus.i_size  = 2'b11;
      bus.i_sign  = 1'b0;
      bus.i_addr  = 32'h0000_9000;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid_req");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mem_q.delete();
      repeat (6) @(posedge clk);
      #1;
    end
    issue(1'b0, 2'b11, 1'b0, 32'h0000_A004, 32'h0, 32'h0BAD_CAFE, 1);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom,
            $urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", 32'(exp_q.size() + mem_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
